// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack: stackOP codes and the upstream push-source codes.
package stack_pkg;

  localparam logic [2:0] SOP_HOLD = 3'd0;
  localparam logic [2:0] SOP_PUSH = 3'd1;
  localparam logic [2:0] SOP_BIN  = 3'd2;
  localparam logic [2:0] SOP_POP  = 3'd3;
  localparam logic [2:0] SOP_POP2 = 3'd4;
  localparam logic [2:0] SOP_SWAP = 3'd5;

  // Source select used by stackControl to build din; not decoded inside the stack.
  typedef enum logic [2:0] {
    SRC_IMM   = 3'd0,
    SRC_LUI   = 3'd1,
    SRC_MEM   = 3'd2,
    SRC_ALU   = 3'd3,
    SRC_INPUT = 3'd4
  } stack_src_t;

  // Codes 6 and 7 are reserved and behave as hold.
  function automatic logic sop_is_defined(input logic [2:0] op);
    return op <= SOP_SWAP;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Spill storage for entries below top/next: one synchronous write port, two asynchronous read ports.
module stack_ram #(
  parameter int WIDTH = 16,
  parameter int NW    = 14,
  parameter int AW    = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic             CLK,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr_a,
  input  logic [AW-1:0]    i_raddr_b,
  output logic [WIDTH-1:0] o_rdata_a,
  output logic [WIDTH-1:0] o_rdata_b
);

  logic [WIDTH-1:0] r_mem [NW];

  // Out-of-range addresses only arise when guards are disabled; keep them harmless.
  always_ff @(posedge CLK) begin
    if (i_we && (int'(i_waddr) < NW)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (int'(i_raddr_a) < NW) ? r_mem[i_raddr_a] : '0;
  assign o_rdata_b = (int'(i_raddr_b) < NW) ? r_mem[i_raddr_b] : '0;

endmodule

// File: rtl/data_stack_unit.sv
// Operand stack: registered top/next plus a spill RAM, one stackOP per clock.
// Build option DSTACK_CHECK_EN enables occupancy guards and sticky overflow/underflow flags.
module data_stack_unit
  import stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [2:0]       stackOP,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] next,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int NW = DEPTH - 2;
  localparam int AW = (NW > 1) ? $clog2(NW) : 1;

  logic [WIDTH-1:0] r_top, r_next;
  logic [CW-1:0]    r_count;

  logic [WIDTH-1:0] w_top_next, w_next_next;
  logic [CW-1:0]    w_count_next;
  logic [CW-1:0]    w_b, w_bm1, w_bm2;
  logic [WIDTH-1:0] w_rd_a, w_rd_b, w_mem1, w_mem2;
  logic             w_we;
  logic [2:0]       w_op;
  logic             w_ok_push, w_ok_two, w_ok_one;

  assign w_op  = sop_is_defined(stackOP) ? stackOP : SOP_HOLD;
  assign w_b   = r_count - CW'(2);
  assign w_bm1 = w_b - CW'(1);
  assign w_bm2 = w_b - CW'(2);

  stack_ram #(
    .WIDTH (WIDTH),
    .NW    (NW),
    .AW    (AW)
  ) u_ram (
    .CLK       (CLK),
    .i_we      (w_we),
    .i_waddr   (w_b[AW-1:0]),
    .i_wdata   (r_next),
    .i_raddr_a (w_bm1[AW-1:0]),
    .i_raddr_b (w_bm2[AW-1:0]),
    .o_rdata_a (w_rd_a),
    .o_rdata_b (w_rd_b)
  );

  // Empty RAM slots must read as zero so vacated top/next come back clean.
  assign w_mem1 = (r_count >= CW'(3)) ? w_rd_a : '0;
  assign w_mem2 = (r_count >= CW'(4)) ? w_rd_b : '0;

`ifdef DSTACK_CHECK_EN
  assign w_ok_push = r_count <  CW'(DEPTH);
  assign w_ok_two  = r_count >= CW'(2);
  assign w_ok_one  = r_count >= CW'(1);
`else
  assign w_ok_push = 1'b1;
  assign w_ok_two  = 1'b1;
  assign w_ok_one  = 1'b1;
`endif

  always_comb begin
    w_top_next   = r_top;
    w_next_next  = r_next;
    w_count_next = r_count;
    w_we         = 1'b0;
    case (w_op)
      SOP_PUSH: if (w_ok_push) begin
        w_we         = (r_count >= CW'(2));
        w_next_next  = r_top;
        w_top_next   = din;
        w_count_next = r_count + CW'(1);
      end
      SOP_BIN: if (w_ok_two) begin
        w_top_next   = din;
        w_next_next  = w_mem1;
        w_count_next = r_count - CW'(1);
      end
      SOP_POP: if (w_ok_one) begin
        w_top_next   = r_next;
        w_next_next  = w_mem1;
        w_count_next = r_count - CW'(1);
      end
      SOP_POP2: if (w_ok_two) begin
        w_top_next   = w_mem1;
        w_next_next  = w_mem2;
        w_count_next = r_count - CW'(2);
      end
      SOP_SWAP: if (w_ok_two) begin
        w_top_next  = r_next;
        w_next_next = r_top;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_top   <= '0;
      r_next  <= '0;
      r_count <= '0;
    end else begin
      r_top   <= w_top_next;
      r_next  <= w_next_next;
      r_count <= w_count_next;
    end
  end

`ifdef DSTACK_CHECK_EN
  logic r_overflow, r_underflow;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_op == SOP_PUSH && !w_ok_push) r_overflow <= 1'b1;
      if (((w_op == SOP_BIN || w_op == SOP_POP2 || w_op == SOP_SWAP) && !w_ok_two) ||
          (w_op == SOP_POP && !w_ok_one)) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign top   = r_top;
  assign next  = r_next;
  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));

endmodule
